// File: rtl/bus_dev_port.sv
// Per-device bus endpoint: transmit FIFO toward the arbiter, ID-filtered receive FIFO toward the host.
// Latency: 1 cycle from enqueue to head visibility on either side; all outputs decoded from registers.
// Backpressure: none upstream; full-FIFO writes are dropped and flagged sticky. Filter macro: BUS_DEV_RX_FILTER_EN.

// Generic first-word-fall-through FIFO with sticky overflow flag.
// Latency: enqueued word is at the head the cycle after the write edge.
// Backpressure: a write to a full FIFO is dropped unless a dequeue frees the slot in the same cycle.
module bus_dev_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_vld,
    input  logic [W-1:0]               in_dat,
    input  logic                       out_rdy,
    output logic                       out_vld,
    output logic [W-1:0]               out_dat,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic                       ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovf_q;
    logic          deq;
    logic          enq;
    logic          at_full;

    // A dequeue needs a visible head; a full FIFO still accepts a write if the head leaves this cycle.
    assign at_full = (count == CW'(DEPTH));
    assign deq     = out_rdy && (count != '0);
    assign enq     = in_vld && (!at_full || deq);

    // Storage is not reset; the head is masked while empty so stale data never leaks out.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // Pointer, occupancy and sticky-overflow bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (enq && !deq) begin
                count <= count + 1'b1;
            end else if (!enq && deq) begin
                count <= count - 1'b1;
            end
            if (in_vld && !enq) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign out_vld = (count != '0);
    assign out_dat = out_vld ? mem[rd_ptr] : '0;
    assign full    = at_full;
    assign cnt     = count;
    assign ovf     = ovf_q;
endmodule

module bus_dev_port #(
    parameter int         pckg_sz   = 16,
    parameter int         depth     = 8,
    parameter logic [7:0] id        = 8'd0,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [pckg_sz-1:0]       wr_data,
    output logic                     tx_full,
    output logic                     pndng,
    output logic [pckg_sz-1:0]       D_pop,
    input  logic                     pop,
    input  logic                     push,
    input  logic [pckg_sz-1:0]       D_push,
    output logic                     rx_valid,
    output logic [pckg_sz-1:0]       rd_data,
    input  logic                     rd_en,
    output logic                     tx_ovf,
    output logic                     rx_ovf,
    output logic [$clog2(depth):0]   rx_cnt
);
    logic                   accept;
    logic [$clog2(depth):0] tx_cnt_unused;
    logic                   rx_full_unused;

`ifdef BUS_DEV_RX_FILTER_EN
    logic [7:0] dst;
    // Accept only packets addressed to this device or to everyone.
    assign dst    = D_push[pckg_sz-1 -: 8];
    assign accept = push && ((dst == id) || (dst == broadcast));
`else
    logic unused_cfg;
    // Unfiltered build: every delivered packet is taken; the ID parameters have no effect.
    assign accept     = push;
    assign unused_cfg = ^{id, broadcast};
`endif

    bus_dev_fifo #(.W(pckg_sz), .DEPTH(depth)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (wr_en),
        .in_dat  (wr_data),
        .out_rdy (pop),
        .out_vld (pndng),
        .out_dat (D_pop),
        .full    (tx_full),
        .cnt     (tx_cnt_unused),
        .ovf     (tx_ovf)
    );

    bus_dev_fifo #(.W(pckg_sz), .DEPTH(depth)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (accept),
        .in_dat  (D_push),
        .out_rdy (rd_en),
        .out_vld (rx_valid),
        .out_dat (rd_data),
        .full    (rx_full_unused),
        .cnt     (rx_cnt),
        .ovf     (rx_ovf)
    );
endmodule
